// File: rtl/tlb_pkg.sv
// Shared TLB types, page-size and INVTLB op encodings, and the match helpers
// used by both the search ports and the invalidate sweep.
package tlb_pkg;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G          = 5'd2;
    localparam logic [4:0] INV_NG         = 5'd3;
    localparam logic [4:0] INV_NG_ASID    = 5'd4;
    localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GVA        = 5'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } tlb_state_e;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_data_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    // A 4M page ignores the low ten VPPN bits.
    function automatic logic va_match(input logic [18:0] ent_vppn, input logic [5:0] ps,
                                      input logic [18:0] vppn);
        return (ent_vppn[18:10] == vppn[18:10]) && ((ps == PS_4M) || (ent_vppn[9:0] == vppn[9:0]));
    endfunction

    function automatic logic page_odd(input logic [5:0] ps, input logic va_bit12,
                                      input logic vppn_bit8);
        return ((ps == PS_4K) && va_bit12) || ((ps == PS_4M) && vppn_bit8);
    endfunction

    function automatic tlb_page_t select_page(input tlb_data_t d, input logic odd);
        tlb_page_t p;
        if (odd) p = '{ppn: d.ppn1, plv: d.plv1, mat: d.mat1, d: d.d1, v: d.v1};
        else     p = '{ppn: d.ppn0, plv: d.plv0, mat: d.mat0, d: d.d0, v: d.v0};
        return p;
    endfunction

endpackage

// File: rtl/tlb_sweep_if.sv
// Bus bundle for tlb_sweep: two search ports, write/read ports, INVTLB handshake.
// With TLB_PERF_CNT_EN defined it also carries the search request strobes and hit/miss counters.
interface tlb_sweep_if #(
    parameter int TLBNUM = 16
);
    localparam int IDXW = $clog2(TLBNUM);

    logic [18:0]     s0_vppn;
    logic            s0_va_bit12;
    logic [9:0]      s0_asid;
    logic            s0_found;
    logic [IDXW-1:0] s0_index;
    logic [19:0]     s0_ppn;
    logic [5:0]      s0_ps;
    logic [1:0]      s0_plv;
    logic [1:0]      s0_mat;
    logic            s0_d;
    logic            s0_v;

    logic [18:0]     s1_vppn;
    logic            s1_va_bit12;
    logic [9:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic [19:0]     s1_ppn;
    logic [5:0]      s1_ps;
    logic [1:0]      s1_plv;
    logic [1:0]      s1_mat;
    logic            s1_d;
    logic            s1_v;

    logic            we;
    logic            w_ready;
    logic [IDXW-1:0] w_index;
    logic            w_e;
    logic [18:0]     w_vppn;
    logic [5:0]      w_ps;
    logic [9:0]      w_asid;
    logic            w_g;
    logic [19:0]     w_ppn0;
    logic [1:0]      w_plv0;
    logic [1:0]      w_mat0;
    logic            w_d0;
    logic            w_v0;
    logic [19:0]     w_ppn1;
    logic [1:0]      w_plv1;
    logic [1:0]      w_mat1;
    logic            w_d1;
    logic            w_v1;

    logic [IDXW-1:0] r_index;
    logic            r_e;
    logic [18:0]     r_vppn;
    logic [5:0]      r_ps;
    logic [9:0]      r_asid;
    logic            r_g;
    logic [19:0]     r_ppn0;
    logic [1:0]      r_plv0;
    logic [1:0]      r_mat0;
    logic            r_d0;
    logic            r_v0;
    logic [19:0]     r_ppn1;
    logic [1:0]      r_plv1;
    logic [1:0]      r_mat1;
    logic            r_d1;
    logic            r_v1;

    logic            inv_valid;
    logic            inv_ready;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [18:0]     inv_vppn;
    logic            inv_done;
    logic            inv_err;
    logic [IDXW-1:0] fill_index;

`ifdef TLB_PERF_CNT_EN
    logic            s0_req;
    logic            s1_req;
    logic [31:0]     s0_hit_cnt;
    logic [31:0]     s0_miss_cnt;
    logic [31:0]     s1_hit_cnt;
    logic [31:0]     s1_miss_cnt;
`endif

    modport master (
`ifdef TLB_PERF_CNT_EN
        output s0_req, s1_req,
        input  s0_hit_cnt, s0_miss_cnt, s1_hit_cnt, s1_miss_cnt,
`endif
        output s0_vppn, s0_va_bit12, s0_asid,
        input  s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
        output s1_vppn, s1_va_bit12, s1_asid,
        input  s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
        output we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
        output w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
        input  w_ready,
        output r_index,
        input  r_e, r_vppn, r_ps, r_asid, r_g,
        input  r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
        output inv_valid, inv_op, inv_asid, inv_vppn,
        input  inv_ready, inv_done, inv_err, fill_index
    );

    modport slave (
`ifdef TLB_PERF_CNT_EN
        input  s0_req, s1_req,
        output s0_hit_cnt, s0_miss_cnt, s1_hit_cnt, s1_miss_cnt,
`endif
        input  s0_vppn, s0_va_bit12, s0_asid,
        output s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
        input  s1_vppn, s1_va_bit12, s1_asid,
        output s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
        input  we, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
        input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
        output w_ready,
        input  r_index,
        output r_e, r_vppn, r_ps, r_asid, r_g,
        output r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
        input  inv_valid, inv_op, inv_asid, inv_vppn,
        output inv_ready, inv_done, inv_err, fill_index
    );

endinterface

// File: rtl/tlb_match.sv
// Per-port associative comparator with lowest-index priority; index is 0 on a miss.
module tlb_match
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic [18:0]       vppn_i,
    input  logic [9:0]        asid_i,
    input  logic [TLBNUM-1:0] e_i,
    input  tlb_key_t          key_i [TLBNUM],
    output logic              found_o,
    output logic [IDXW-1:0]   index_o
);

    logic [TLBNUM-1:0] hit;

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            hit[i] = e_i[i] && (key_i[i].g || (key_i[i].asid == asid_i)) &&
                     va_match(key_i[i].vppn, key_i[i].ps, vppn_i);
        end
    end

    // Scan from the top so the lowest hitting index is the last one assigned.
    always_comb begin
        found_o = |hit;
        index_o = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) index_o = IDXW'(i);
        end
    end

endmodule

// File: rtl/tlb_sweep.sv
// Fully-associative TLB with a multi-cycle INVTLB sweep and a free-running fill index.
// Define TLB_PERF_CNT_EN to add saturating per-port hit/miss counters.
module tlb_sweep
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16
) (
    input logic         clk,
    input logic         resetn,
    tlb_sweep_if.slave  bus
);

    localparam int IDXW = $clog2(TLBNUM);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SWEEP = SWEEP;
    localparam logic [1:0] S_DONE  = DONE;

    tlb_key_t          key_q  [TLBNUM];
    tlb_data_t         data_q [TLBNUM];
    logic [TLBNUM-1:0] e_q, e_d;
    logic [1:0]        state_q, state_d;
    logic [IDXW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   fill_q;
    logic              err_q, err_d;
    logic [4:0]        op_q;
    logic [9:0]        asid_q;
    logic [18:0]       vppn_q;

    logic              wr_en, accept, inv_hit;
    tlb_key_t          sk;
    logic              found0, found1;
    logic [IDXW-1:0]   idx0, idx1;
    tlb_page_t         pg0, pg1;
    tlb_key_t          rk;
    tlb_data_t         rd;

    assign wr_en  = bus.we && (state_q == S_IDLE);
    assign accept = bus.inv_valid && (state_q == S_IDLE) && (bus.inv_op <= INV_GVA);

    // Entry payload and the latched INVTLB operands carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q[bus.w_index]  <= '{vppn: bus.w_vppn, ps: bus.w_ps, asid: bus.w_asid, g: bus.w_g};
            data_q[bus.w_index] <= '{ppn0: bus.w_ppn0, plv0: bus.w_plv0, mat0: bus.w_mat0,
                                     d0: bus.w_d0, v0: bus.w_v0,
                                     ppn1: bus.w_ppn1, plv1: bus.w_plv1, mat1: bus.w_mat1,
                                     d1: bus.w_d1, v1: bus.w_v1};
        end
        if (accept) begin
            op_q   <= bus.inv_op;
            asid_q <= bus.inv_asid;
            vppn_q <= bus.inv_vppn;
        end
    end

    always_comb begin
        sk = key_q[cnt_q];
        case (op_q)
            INV_ALL0, INV_ALL1: inv_hit = 1'b1;
            INV_G:              inv_hit = sk.g;
            INV_NG:             inv_hit = !sk.g;
            INV_NG_ASID:        inv_hit = !sk.g && (sk.asid == asid_q);
            INV_NG_ASID_VA:     inv_hit = !sk.g && (sk.asid == asid_q) && va_match(sk.vppn, sk.ps, vppn_q);
            INV_GVA:            inv_hit = (sk.g || (sk.asid == asid_q)) && va_match(sk.vppn, sk.ps, vppn_q);
            default:            inv_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_en) e_d[bus.w_index] = bus.w_e;
                if (accept) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                end else if (bus.inv_valid) begin
                    err_d = 1'b1;
                end
            end
            S_SWEEP: begin
                if (inv_hit) e_d[cnt_q] = 1'b0;
                cnt_d = cnt_q + IDXW'(1);
                if (cnt_q == IDXW'(TLBNUM - 1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            e_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_q + IDXW'(1);
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

    assign bus.w_ready    = (state_q == S_IDLE);
    assign bus.inv_ready  = (state_q == S_IDLE);
    assign bus.inv_done   = (state_q == S_DONE);
    assign bus.inv_err    = err_q;
    assign bus.fill_index = fill_q;

    tlb_match #(.TLBNUM(TLBNUM)) u_match0 (
        .vppn_i  (bus.s0_vppn),
        .asid_i  (bus.s0_asid),
        .e_i     (e_q),
        .key_i   (key_q),
        .found_o (found0),
        .index_o (idx0)
    );

    tlb_match #(.TLBNUM(TLBNUM)) u_match1 (
        .vppn_i  (bus.s1_vppn),
        .asid_i  (bus.s1_asid),
        .e_i     (e_q),
        .key_i   (key_q),
        .found_o (found1),
        .index_o (idx1)
    );

    assign pg0 = select_page(data_q[idx0], page_odd(key_q[idx0].ps, bus.s0_va_bit12, bus.s0_vppn[8]));
    assign pg1 = select_page(data_q[idx1], page_odd(key_q[idx1].ps, bus.s1_va_bit12, bus.s1_vppn[8]));

    assign bus.s0_found = found0;
    assign bus.s0_index = idx0;
    assign bus.s0_ps    = key_q[idx0].ps;
    assign bus.s0_ppn   = pg0.ppn;
    assign bus.s0_plv   = pg0.plv;
    assign bus.s0_mat   = pg0.mat;
    assign bus.s0_d     = pg0.d;
    assign bus.s0_v     = pg0.v;

    assign bus.s1_found = found1;
    assign bus.s1_index = idx1;
    assign bus.s1_ps    = key_q[idx1].ps;
    assign bus.s1_ppn   = pg1.ppn;
    assign bus.s1_plv   = pg1.plv;
    assign bus.s1_mat   = pg1.mat;
    assign bus.s1_d     = pg1.d;
    assign bus.s1_v     = pg1.v;

    assign rk = key_q[bus.r_index];
    assign rd = data_q[bus.r_index];

    assign bus.r_e    = e_q[bus.r_index];
    assign bus.r_vppn = rk.vppn;
    assign bus.r_ps   = rk.ps;
    assign bus.r_asid = rk.asid;
    assign bus.r_g    = rk.g;
    assign bus.r_ppn0 = rd.ppn0;
    assign bus.r_plv0 = rd.plv0;
    assign bus.r_mat0 = rd.mat0;
    assign bus.r_d0   = rd.d0;
    assign bus.r_v0   = rd.v0;
    assign bus.r_ppn1 = rd.ppn1;
    assign bus.r_plv1 = rd.plv1;
    assign bus.r_mat1 = rd.mat1;
    assign bus.r_d1   = rd.d1;
    assign bus.r_v1   = rd.v1;

`ifdef TLB_PERF_CNT_EN
    logic [31:0] s0_hit_q, s0_miss_q, s1_hit_q, s1_miss_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return (en && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_hit_q  <= '0;
            s0_miss_q <= '0;
            s1_hit_q  <= '0;
            s1_miss_q <= '0;
        end else begin
            s0_hit_q  <= sat_inc(s0_hit_q,  bus.s0_req && found0);
            s0_miss_q <= sat_inc(s0_miss_q, bus.s0_req && !found0);
            s1_hit_q  <= sat_inc(s1_hit_q,  bus.s1_req && found1);
            s1_miss_q <= sat_inc(s1_miss_q, bus.s1_req && !found1);
        end
    end

    assign bus.s0_hit_cnt  = s0_hit_q;
    assign bus.s0_miss_cnt = s0_miss_q;
    assign bus.s1_hit_cnt  = s1_hit_q;
    assign bus.s1_miss_cnt = s1_miss_q;
`endif

endmodule

// File: tb/tb_tlb_sweep.sv
// Bench for tlb_sweep: directed scenarios plus randomized writes, searches and sweeps
// checked against an entry-array reference model.
module tb_tlb_sweep;

    localparam int N = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tlb_sweep_if #(.TLBNUM(N)) bus();

    tlb_sweep #(.TLBNUM(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } ment_t;

    ment_t       m [N];
    logic [18:0] pool [4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ment_t rand_ent();
        ment_t r;
        r      = '0;
        r.e    = ($urandom_range(0, 3) != 0);
        r.vppn = pool[$urandom_range(0, 3)];
        r.ps   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
        r.asid = 10'($urandom_range(0, 2));
        r.g    = 1'($urandom_range(0, 1));
        r.ppn0 = 20'($urandom);
        r.plv0 = 2'($urandom);
        r.mat0 = 2'($urandom);
        r.d0   = 1'($urandom);
        r.v0   = 1'($urandom);
        r.ppn1 = 20'($urandom);
        r.plv1 = 2'($urandom);
        r.mat1 = 2'($urandom);
        r.d1   = 1'($urandom);
        r.v1   = 1'($urandom);
        return r;
    endfunction

    function automatic logic [18:0] rand_vppn();
        logic [18:0] v;
        v = pool[$urandom_range(0, 3)];
        if ($urandom_range(0, 2) == 0) v[9:0] = 10'($urandom);
        if ($urandom_range(0, 7) == 0) v = 19'($urandom);
        return v;
    endfunction

    // Reference lookup: first valid entry satisfying the match rule, entry 0 on a miss.
    function automatic logic [36:0] exp_search(input logic [18:0] v, input logic b12, input logic [9:0] a);
        int    sel;
        logic  f;
        logic  odd;
        ment_t x;
        sel = 0;
        f   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!f && m[i].e && (m[i].g || m[i].asid == a) && m[i].vppn[18:10] == v[18:10] &&
                (m[i].ps == 6'd21 || m[i].vppn[9:0] == v[9:0])) begin
                f   = 1'b1;
                sel = i;
            end
        end
        x   = m[sel];
        odd = (x.ps == 6'd12 && b12) || (x.ps == 6'd21 && v[8]);
        return {f, 4'(sel), x.ps, odd ? x.ppn1 : x.ppn0, odd ? x.plv1 : x.plv0,
                odd ? x.mat1 : x.mat0, odd ? x.d1 : x.d0, odd ? x.v1 : x.v0};
    endfunction

    function automatic bit inv_pred(input int op, input logic [9:0] a, input logic [18:0] v, input ment_t x);
        bit am, vm;
        am = (x.asid == a);
        vm = (x.vppn[18:10] == v[18:10]) && (x.ps == 6'd21 || x.vppn[9:0] == v[9:0]);
        case (op)
            0, 1:    return 1'b1;
            2:       return x.g;
            3:       return !x.g;
            4:       return !x.g && am;
            5:       return !x.g && am && vm;
            6:       return (x.g || am) && vm;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_inv(input int op, input logic [9:0] a, input logic [18:0] v);
        for (int i = 0; i < N; i++) if (inv_pred(op, a, v, m[i])) m[i].e = 1'b0;
    endtask

    task automatic set_w(input int idx, input ment_t x);
        bus.w_index = 4'(idx);
        bus.w_e = x.e;       bus.w_vppn = x.vppn; bus.w_ps = x.ps; bus.w_asid = x.asid; bus.w_g = x.g;
        bus.w_ppn0 = x.ppn0; bus.w_plv0 = x.plv0; bus.w_mat0 = x.mat0; bus.w_d0 = x.d0; bus.w_v0 = x.v0;
        bus.w_ppn1 = x.ppn1; bus.w_plv1 = x.plv1; bus.w_mat1 = x.mat1; bus.w_d1 = x.d1; bus.w_v1 = x.v1;
    endtask

    task automatic write_entry(input int idx, input ment_t x);
        set_w(idx, x);
        bus.we = 1'b1;
        @(posedge clk); #1;
        bus.we = 1'b0;
        m[idx] = x;
    endtask

    task automatic check_read(input int idx, input string tag);
        bus.r_index = 4'(idx);
        #1;
        chk(tag, 128'({bus.r_e, bus.r_vppn, bus.r_ps, bus.r_asid, bus.r_g,
                       bus.r_ppn0, bus.r_plv0, bus.r_mat0, bus.r_d0, bus.r_v0,
                       bus.r_ppn1, bus.r_plv1, bus.r_mat1, bus.r_d1, bus.r_v1}), 128'(m[idx]));
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) check_read(i, tag);
    endtask

    task automatic check_search(input string tag, input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                                input logic [18:0] v1, input logic b1, input logic [9:0] a1);
        bus.s0_vppn = v0; bus.s0_va_bit12 = b0; bus.s0_asid = a0;
        bus.s1_vppn = v1; bus.s1_va_bit12 = b1; bus.s1_asid = a1;
        #1;
        chk({tag, "_s0"}, 128'({bus.s0_found, bus.s0_index, bus.s0_ps, bus.s0_ppn, bus.s0_plv,
                                bus.s0_mat, bus.s0_d, bus.s0_v}), 128'(exp_search(v0, b0, a0)));
        chk({tag, "_s1"}, 128'({bus.s1_found, bus.s1_index, bus.s1_ps, bus.s1_ppn, bus.s1_plv,
                                bus.s1_mat, bus.s1_d, bus.s1_v}), 128'(exp_search(v1, b1, a1)));
    endtask

    task automatic rand_search(input string tag);
        check_search(tag, rand_vppn(), 1'($urandom), 10'($urandom_range(0, 3)),
                     rand_vppn(), 1'($urandom), 10'($urandom_range(0, 3)));
    endtask

    // Issue an INVTLB op from IDLE, require inv_done exactly TLBNUM+1 cycles after acceptance.
    task automatic run_inv(input string tag, input int op, input logic [9:0] a, input logic [18:0] v);
        int k;
        bus.inv_op = 5'(op); bus.inv_asid = a; bus.inv_vppn = v; bus.inv_valid = 1'b1;
        @(posedge clk); #1;
        bus.inv_valid = 1'b0;
        k = 1;
        while (!bus.inv_done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_done_latency"}, 128'(k), 128'(N + 1));
        @(posedge clk); #1;
        chk({tag, "_back_idle"}, 128'({bus.inv_ready, bus.inv_done}), 128'(2'b10));
        model_inv(op, a, v);
    endtask

    initial begin
        ment_t x;
        int    bad_ready, early, done_seen;

        for (int i = 0; i < 4; i++) pool[i] = 19'($urandom);
        for (int i = 0; i < N; i++) m[i] = '0;
        resetn = 1'b0;
        bus.s0_vppn = '0; bus.s0_va_bit12 = 1'b0; bus.s0_asid = '0;
        bus.s1_vppn = '0; bus.s1_va_bit12 = 1'b0; bus.s1_asid = '0;
        bus.we = 1'b0; set_w(0, '0);
        bus.r_index = '0;
        bus.inv_valid = 1'b0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
`ifdef TLB_PERF_CNT_EN
        bus.s0_req = 1'b0; bus.s1_req = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_handshake", 128'({bus.inv_ready, bus.w_ready, bus.inv_done, bus.inv_err}), 128'(4'b1100));
        chk("rst_fill", 128'(bus.fill_index), 128'(0));
        resetn = 1'b1;
        #1;
        chk("rst_fill_release", 128'(bus.fill_index), 128'(0));
        for (int i = 0; i < N; i++) begin
            bus.r_index = 4'(i); #1;
            chk("rst_e_clear", 128'(bus.r_e), 128'(0));
        end
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) write_entry(i, '0);

        // 4K page, odd half selected by VA[12]; ASID mismatch misses
        x = '0; x.e = 1'b1; x.vppn = 19'h00012; x.asid = 10'd5; x.ps = 6'd12;
        x.ppn0 = 20'h100; x.ppn1 = 20'h101; x.v0 = 1'b1; x.v1 = 1'b1;
        write_entry(3, x);
        check_search("t1", 19'h00012, 1'b1, 10'd5, 19'h00012, 1'b0, 10'd5);
        chk("t1_found_idx", 128'({bus.s0_found, bus.s0_index}), 128'({1'b1, 4'd3}));
        chk("t1_ppn_odd", 128'(bus.s0_ppn), 128'(20'h101));
        chk("t1_ppn_even", 128'(bus.s1_ppn), 128'(20'h100));
        check_search("t1_asid6", 19'h00012, 1'b1, 10'd6, 19'h00013, 1'b1, 10'd5);
        chk("t1_asid6_miss", 128'(bus.s0_found), 128'(0));

        // 4M global page, odd half chosen by VPPN[8]
        x = '0; x.e = 1'b1; x.vppn = 19'h00500; x.asid = 10'd1; x.ps = 6'd21; x.g = 1'b1;
        x.ppn0 = 20'h200; x.ppn1 = 20'h201;
        write_entry(2, x);
        check_search("t2", 19'h005FF, 1'b0, 10'd9, 19'h004FF, 1'b0, 10'd9);
        chk("t2_hit", 128'({bus.s0_found, bus.s0_index, bus.s0_ppn}), 128'({1'b1, 4'd2, 20'h201}));
        chk("t2_even", 128'({bus.s1_found, bus.s1_index, bus.s1_ppn}), 128'({1'b1, 4'd2, 20'h200}));

        // Multi-hit priority, then fall through to the next index
        x = '0; x.e = 1'b1; x.vppn = 19'h03456; x.asid = 10'd7; x.ps = 6'd12; x.ppn0 = 20'h111;
        write_entry(1, x);
        x.ppn0 = 20'h777;
        write_entry(7, x);
        check_search("t3", 19'h03456, 1'b0, 10'd7, 19'h03456, 1'b0, 10'd7);
        chk("t3_lowest", 128'({bus.s0_index, bus.s0_ppn}), 128'({4'd1, 20'h111}));
        x = m[1]; x.e = 1'b0;
        write_entry(1, x);
        check_search("t3b", 19'h03456, 1'b0, 10'd7, 19'h03456, 1'b0, 10'd7);
        chk("t3_next", 128'(bus.s0_index), 128'(7));

        // Randomized writes, searches and reads
        for (int it = 0; it < 50; it++) begin
            write_entry($urandom_range(0, N - 1), rand_ent());
            rand_search("rnd");
            check_read($urandom_range(0, N - 1), "rnd_read");
        end

        // op 2 on alternating G: handshake timing, ignored write, partial state mid-sweep
        for (int i = 0; i < N; i++) begin
            x = rand_ent(); x.e = 1'b1; x.g = 1'(i & 1);
            write_entry(i, x);
        end
        bus.inv_op = 5'd2; bus.inv_asid = '0; bus.inv_vppn = '0; bus.inv_valid = 1'b1;
        @(posedge clk); #1;
        bus.inv_valid = 1'b0;
        bad_ready = 0;
        early = 0;
        for (int k = 1; k <= N + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (bus.inv_ready !== 1'b0) bad_ready++;
            if (k < N + 1 && bus.inv_done !== 1'b0) early++;
            if (k == 5) begin
                set_w(0, rand_ent());
                bus.we = 1'b1;
                #1;
                chk("w_ready_in_sweep", 128'(bus.w_ready), 128'(0));
            end
            if (k == 6) bus.we = 1'b0;
            if (k == 2 || k == 3) begin
                bus.r_index = 4'd1; #1;
                chk((k == 2) ? "mid_sweep_e1_before" : "mid_sweep_e1_after", 128'(bus.r_e), 128'(k == 2));
            end
        end
        chk("inv2_done_T17", 128'(bus.inv_done), 128'(1));
        chk("inv2_ready_low", 128'(bad_ready), 128'(0));
        chk("inv2_no_early_done", 128'(early), 128'(0));
        @(posedge clk); #1;
        chk("inv2_done_pulse", 128'({bus.inv_ready, bus.inv_done}), 128'(2'b10));
        model_inv(2, '0, '0);
        check_all("inv2_entries");

        // Write and INVTLB in the same IDLE cycle: the sweep sees the new entry
        x = rand_ent(); x.e = 1'b1; x.g = 1'b1;
        set_w(4, x);
        bus.we = 1'b1;
        m[4] = x;
        run_inv("wr_inv", 2, '0, '0);
        bus.we = 1'b0;
        check_read(4, "wr_inv_e4");

        // Illegal op
        bus.inv_op = 5'd7; bus.inv_valid = 1'b1;
        @(posedge clk); #1;
        bus.inv_valid = 1'b0;
        chk("op7_err", 128'({bus.inv_err, bus.inv_ready}), 128'(2'b11));
        @(posedge clk); #1;
        chk("op7_err_pulse", 128'(bus.inv_err), 128'(0));
        check_all("op7_entries");

        // Randomized sweeps
        for (int it = 0; it < 5; it++) begin
            for (int j = 0; j < 8; j++) write_entry($urandom_range(0, N - 1), rand_ent());
            run_inv("rnd_inv", $urandom_range(0, 6), 10'($urandom_range(0, 2)), rand_vppn());
            check_all("rnd_inv_entries");
            rand_search("rnd_inv_search");
        end

        // Reset in the middle of an op 0 sweep
        for (int i = 0; i < N; i++) begin
            x = rand_ent(); x.e = 1'b1;
            write_entry(i, x);
        end
        bus.inv_op = 5'd0; bus.inv_valid = 1'b1;
        @(posedge clk); #1;
        bus.inv_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        chk("abort_idle", 128'({bus.inv_ready, bus.w_ready, bus.inv_done}), 128'(3'b110));
        for (int i = 0; i < N; i++) m[i].e = 1'b0;
        check_all("abort_entries");
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
        chk("abort_fill0", 128'(bus.fill_index), 128'(0));
        done_seen = 0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            if (bus.inv_done !== 1'b0) done_seen++;
            if (k == N - 1) chk("fill_15", 128'(bus.fill_index), 128'(N - 1));
            if (k == N)     chk("fill_wrap", 128'(bus.fill_index), 128'(0));
        end
        chk("abort_no_done", 128'(done_seen), 128'(0));
        rand_search("post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
